// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and capture FSM state type.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;

    // Counters restart at the sync falling edge, so active video begins after sync + back porch.
    localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_LOCK_FRAMES = 2;

    localparam int               CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQUIRE,
        ST_LOCKED
    } cap_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Falling-edge detector on a sync input, advanced only on pixel-rate enables.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce_i,
    input  logic d_i,
    output logic fall_o
);

    logic d_q;

    // Previous sample; cleared to 0 so a sync already low at reset is not taken as an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i)     d_q <= 1'b0;
        else if (ce_i) d_q <= d_i;
    end

    assign fall_o = ce_i & d_q & ~d_i;

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel coordinates from HS/VS, measures line/frame
// length, and locks once the raster matches the expected timing.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        hs,
    input  logic        vs,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] rgb_out,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [9:0]  h_total_meas,
    output logic [9:0]  v_total_meas
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HA_LO  = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] HA_HI  = CNT_W'(H_ACT_START + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VA_LO  = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] VA_HI  = CNT_W'(V_ACT_START + V_ACTIVE - 1);
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    logic             hs_fall, vs_fall;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic             vs_seen_q, vs_seen_d, line_bad_q, line_bad_d;
    logic [11:0]      rgb_q;
    logic             ce_q, err_q;
    logic [3:0]       good_q, good_d;
    cap_state_e       state_q, state_d;
    logic             h_sat, line_err, frame_err, frame_ok, lock_loss, act;

    sync_edge_det u_hs_det (.clk_i(clk), .rst_i(rst), .ce_i(pix_ce), .d_i(hs), .fall_o(hs_fall));
    sync_edge_det u_vs_det (.clk_i(clk), .rst_i(rst), .ce_i(pix_ce), .d_i(vs), .fall_o(vs_fall));

    // Timing checks; lines are only judged once a VS fall has anchored the raster.
    always_comb begin
        h_sat     = (h_cnt_q == CNT_MAX);
        line_err  = vs_seen_q && ((hs_fall && h_cnt_q != H_LAST) ||
                                  (pix_ce && !hs_fall && h_sat));
        frame_err = vs_fall && (v_cnt_q != V_LAST);
    end

    // Raster counters and measurements; VS fall overrides the HS-driven line count.
    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        h_meas_d   = h_meas_q;
        v_meas_d   = v_meas_q;
        vs_seen_d  = vs_seen_q;
        line_bad_d = line_bad_q;
        if (pix_ce) begin
            if (hs_fall) begin
                h_cnt_d  = '0;
                h_meas_d = h_sat ? CNT_MAX : h_cnt_q + 1'b1;
                if (v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 1'b1;
            end else if (!h_sat) begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            if (line_err) line_bad_d = 1'b1;
            if (vs_fall) begin
                v_meas_d   = (v_cnt_q == CNT_MAX) ? CNT_MAX : v_cnt_q + 1'b1;
                v_cnt_d    = '0;
                vs_seen_d  = 1'b1;
                line_bad_d = 1'b0;
            end
        end
    end

    // Lock FSM: search for a frame boundary, count clean frames, drop on any error.
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        lock_loss = 1'b0;
        frame_ok  = !line_bad_q && !line_err && !frame_err;
        unique case (state_q)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (vs_fall) begin
                    if (frame_ok) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 >= LOCK_N) state_d = ST_LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end else if (line_err) begin
                    good_d = '0;
                end
            end
            ST_LOCKED: begin
                if (line_err || frame_err) begin
                    lock_loss = 1'b1;
                    state_d   = ST_SEARCH;
                    good_d    = '0;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Stage 1: sampled inputs, counters and one-clk markers for stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            h_meas_q   <= '0;
            v_meas_q   <= '0;
            vs_seen_q  <= 1'b0;
            line_bad_q <= 1'b0;
            rgb_q      <= '0;
            ce_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            h_meas_q   <= h_meas_d;
            v_meas_q   <= v_meas_d;
            vs_seen_q  <= vs_seen_d;
            line_bad_q <= line_bad_d;
            if (pix_ce) rgb_q <= rgb_in;
            ce_q       <= pix_ce;
            err_q      <= lock_loss;
        end
    end

    // A pixel is valid only on a fresh sample inside the active window while locked;
    // state_q has already left LOCKED for the sample that caused a lock loss.
    always_comb begin
        act = ce_q && (state_q == ST_LOCKED) &&
              (h_cnt_q >= HA_LO) && (h_cnt_q <= HA_HI) &&
              (v_cnt_q >= VA_LO) && (v_cnt_q <= VA_HI);
    end

    // Stage 2: output registers; coordinates and colour hold between valid pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            rgb_out     <= '0;
        end else begin
            pix_valid   <= act;
            frame_start <= act && (h_cnt_q == HA_LO) && (v_cnt_q == VA_LO);
            locked      <= (state_q == ST_LOCKED);
            timing_err  <= err_q;
            if (act) begin
                pix_x   <= h_cnt_q - HA_LO;
                pix_y   <= v_cnt_q - VA_LO;
                rgb_out <= rgb_q;
            end
        end
    end

    assign h_total_meas = h_meas_q;
    assign v_total_meas = v_meas_q;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced raster (20x12 total, 10x6 active)
// so many frames fit in a short run; pix_ce fires every 4th clock.
module tb_vga_capture;

    localparam int H_T = 20, V_T = 12;
    localparam int H_SYNC = 2, V_SYNC = 2;
    localparam int H_AS = 6, V_AS = 3;
    localparam int H_A = 10, V_A = 6;

    logic        clk = 1'b0;
    logic        rst, pix_ce, hs, vs;
    logic [11:0] rgb_in;
    logic [9:0]  pix_x, pix_y, h_total_meas, v_total_meas;
    logic [11:0] rgb_out;
    logic        pix_valid, frame_start, locked, timing_err;

    int n_vec = 0, n_bad = 0;
    int vld_cnt = 0, terr_cnt = 0, n_push = 0;
    logic [32:0] sb[$];

    typedef struct {
        int lines, short_line, valid_lt;
        int cp_line, cp_lock, cp_h, cp_v, cp_terr;
        int rst_line, pause_line;
    } frame_t;

    vga_capture #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACT_START(H_AS), .V_ACT_START(V_AS),
        .H_ACTIVE(H_A), .V_ACTIVE(V_A), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .hs(hs), .vs(vs), .rgb_in(rgb_in),
        .pix_x(pix_x), .pix_y(pix_y), .rgb_out(rgb_out), .pix_valid(pix_valid),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every valid pixel.
    always @(negedge clk) begin
        if (timing_err === 1'b1) terr_cnt++;
        if (frame_start === 1'b1 && pix_valid !== 1'b1)
            chk("frame_start_without_valid", 64'(frame_start), 64'd0);
        if (pix_valid === 1'b1) begin
            vld_cnt++;
            if (sb.size() == 0) chk("unexpected_pix_valid", 64'(pix_valid), 64'd0);
            else chk("pixel", {frame_start, pix_x, pix_y, rgb_out}, sb.pop_front());
        end
    end

    task automatic sample(input logic h, input logic v, input logic [11:0] c);
        hs = h; vs = v; rgb_in = c; pix_ce = 1'b1;
        @(posedge clk); #1;
        pix_ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic frame_t frm(input int valid_lt);
        frame_t f;
        f.lines = V_T; f.short_line = -1; f.valid_lt = valid_lt;
        f.cp_line = -1; f.cp_lock = 0; f.cp_h = 0; f.cp_v = 0; f.cp_terr = 0;
        f.rst_line = -1; f.pause_line = -1;
        return f;
    endfunction

    function automatic frame_t with_cp(input frame_t f, input int line, input int lk,
                                       input int h, input int v, input int terr);
        frame_t g = f;
        g.cp_line = line; g.cp_lock = lk; g.cp_h = h; g.cp_v = v; g.cp_terr = terr;
        return g;
    endfunction

    // Drives one raster frame; pushes expected pixels for lines below valid_lt.
    task automatic run_frame(input frame_t f);
        int len, ax, ay, base_vld, base_push, pre_vld;
        logic [11:0] c;
        base_vld = vld_cnt; base_push = n_push;
        for (int y = 0; y < f.lines; y++) begin
            len = (y == f.short_line) ? H_T - 1 : H_T;
            for (int x = 0; x < len; x++) begin
                if (x == 0 && y == f.rst_line) begin
                    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
                    chk("reset_mid_frame", {pix_valid, frame_start, locked, timing_err, pix_x,
                        pix_y, rgb_out, h_total_meas, v_total_meas}, 64'd0);
                end
                if (x == 0 && y == f.pause_line) begin
                    pre_vld = vld_cnt;
                    repeat (1000) @(posedge clk);
                    #1;
                    chk("ce_pause_hold", {locked, h_total_meas, v_total_meas, 32'(vld_cnt - pre_vld)},
                        {1'b1, 10'(H_T), 10'(V_T), 32'd0});
                end
                ax = x - H_AS; ay = y - V_AS;
                c = {ax[3:0], ay[3:0], 4'hA};
                if (y < f.valid_lt && x >= H_AS && x < H_AS + H_A && y >= V_AS && y < V_AS + V_A) begin
                    sb.push_back({(ax == 0 && ay == 0), 10'(ax), 10'(ay), c});
                    n_push++;
                end
                sample(x >= H_SYNC, y >= V_SYNC, c);
                if (x == 0 && y == f.cp_line)
                    chk("checkpoint", {locked, h_total_meas, v_total_meas, 32'(terr_cnt)},
                        {1'(f.cp_lock), 10'(f.cp_h), 10'(f.cp_v), 32'(f.cp_terr)});
            end
        end
        chk("frame_valid_count", 64'(vld_cnt - base_vld), 64'(n_push - base_push));
    endtask

    initial begin
        frame_t f;
        rst = 1'b1; pix_ce = 1'b0; hs = 1'b1; vs = 1'b1; rgb_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", {pix_valid, frame_start, locked, timing_err, pix_x, pix_y, rgb_out,
            h_total_meas, v_total_meas}, 64'd0);
        repeat (5) sample(1'b1, 1'b1, 12'h000);

        // First VS fall at F0 start, two clean frames, lock at F2 start.
        run_frame(frm(0));
        run_frame(with_cp(frm(0), 0, 0, H_T, V_T, 0));
        run_frame(with_cp(frm(V_T), 0, 1, H_T, V_T, 0));

        // Line 5 is one tick short: lock lost at line 6 start, relock two frames later.
        f = with_cp(frm(6), 6, 0, H_T - 1, V_T, 1);
        f.short_line = 5;
        run_frame(f);
        run_frame(with_cp(frm(0), 0, 0, H_T, V_T, 1));
        run_frame(frm(0));
        run_frame(with_cp(frm(V_T), 0, 1, H_T, V_T, 1));

        // One frame a line short: error at next VS fall.
        f = frm(V_T);
        f.lines = V_T - 1;
        run_frame(f);
        run_frame(with_cp(frm(0), 0, 0, H_T, V_T - 1, 2));
        run_frame(frm(0));
        run_frame(frm(0));
        run_frame(with_cp(frm(V_T), 0, 1, H_T, V_T, 2));

        // Reset at line 5; HS falls on lines 6..11 leave v_cnt=6 at the next VS fall.
        f = frm(5);
        f.rst_line = 5;
        run_frame(f);
        run_frame(with_cp(frm(0), 0, 0, H_T, 7, 2));
        run_frame(with_cp(frm(0), 0, 0, H_T, V_T, 2));

        // Locked again; pix_ce held low for 1000 clocks in active line 4.
        f = with_cp(frm(V_T), 0, 1, H_T, V_T, 2);
        f.pause_line = 4;
        run_frame(f);
        run_frame(with_cp(frm(V_T), 0, 1, H_T, V_T, 2));

        repeat (8) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
